// File: rtl/button_cond.sv
// button_cond: per-button 2-flop synchronizer, debouncer and press-pulse generator with
// per-player up/down exclusion. Define BTN_AUTOREPEAT_EN to compile in held-button auto-repeat.
module button_cond #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [1:0] conflict
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Repeat intervals below 2 would let a bit pulse on back-to-back cycles.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_param_check
        $error("button_cond: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 2");
    end

    // Outputs are plain levels and single-cycle pulses: there is no valid/ready
    // handshake, and a pulse that no consumer samples is simply lost.
    logic [3:0]    sync_meta;
    logic [3:0]    sync;
    logic [CW-1:0] db_cnt     [4];
    logic [CW-1:0] db_cnt_nxt [4];
    logic [3:0]    level_nxt;
    logic [3:0]    press_nxt;
    logic [3:0]    pulse_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync      <= sync_meta;
        end
    end

    always_comb begin
        level_nxt = btn_level;
        for (int i = 0; i < 4; i++) begin
            db_cnt_nxt[i] = '0;
            if (sync[i] != btn_level[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    level_nxt[i] = sync[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press fires on the level rise unless the same player's other direction is
    // held in that same cycle (covers both simultaneous rises and an already-held partner).
    always_comb begin
        press_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            press_nxt[i] = level_nxt[i] & ~btn_level[i] & ~level_nxt[i ^ 1];
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW_RAW = (REPEAT_DELAY > REPEAT_RATE) ? $clog2(REPEAT_DELAY) : $clog2(REPEAT_RATE);
    localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [3:0]    rpt_on;
    logic [3:0]    rpt_on_nxt;
    logic [3:0]    rpt_first;
    logic [3:0]    rpt_first_nxt;
    logic [3:0]    rpt_fire;
    logic [RW-1:0] rpt_cnt     [4];
    logic [RW-1:0] rpt_cnt_nxt [4];

    // The timer arms only on an unsuppressed press and disarms on release or
    // when the partner direction becomes held.
    always_comb begin
        rpt_on_nxt    = rpt_on;
        rpt_first_nxt = rpt_first;
        rpt_fire      = '0;
        for (int i = 0; i < 4; i++) begin
            rpt_cnt_nxt[i] = rpt_cnt[i];
            if (press_nxt[i]) begin
                rpt_on_nxt[i]    = 1'b1;
                rpt_first_nxt[i] = 1'b1;
                rpt_cnt_nxt[i]   = '0;
            end else if (!rpt_on[i] || !level_nxt[i] || level_nxt[i ^ 1]) begin
                rpt_on_nxt[i]    = 1'b0;
                rpt_first_nxt[i] = 1'b0;
                rpt_cnt_nxt[i]   = '0;
            end else if (rpt_cnt[i] == (rpt_first[i] ? DELAY_LAST : RATE_LAST)) begin
                rpt_fire[i]      = 1'b1;
                rpt_first_nxt[i] = 1'b0;
                rpt_cnt_nxt[i]   = '0;
            end else begin
                rpt_cnt_nxt[i] = rpt_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_on    <= '0;
            rpt_first <= '0;
            for (int i = 0; i < 4; i++) rpt_cnt[i] <= '0;
        end else begin
            rpt_on    <= rpt_on_nxt;
            rpt_first <= rpt_first_nxt;
            for (int i = 0; i < 4; i++) rpt_cnt[i] <= rpt_cnt_nxt[i];
        end
    end

    assign pulse_nxt = press_nxt | rpt_fire;
`else
    assign pulse_nxt = press_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level <= '0;
            btn_press <= '0;
            conflict  <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            btn_level <= level_nxt;
            btn_press <= pulse_nxt;
            conflict  <= {level_nxt[3] & level_nxt[2], level_nxt[1] & level_nxt[0]};
            for (int i = 0; i < 4; i++) db_cnt[i] <= db_cnt_nxt[i];
        end
    end

endmodule

// File: tb/tb_button_cond.sv
// Testbench for button_cond: directed scenarios plus random button activity, checked
// every cycle against a window-based reference model through an expected-value queue.
module tb_button_cond;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = '0;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [1:0] conflict;

    always #5 clk = ~clk;

    button_cond #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .conflict (conflict)
    );

    // ---------------- scoreboard state ----------------
    logic [9:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // A level takes value v once the last D synchronized samples are all v; the
    // synchronized sample used at edge t is the raw value seen at edge t-2.
    logic [3:0] hist[$];
    logic [3:0] m_level = '0;
    logic [3:0] m_press = '0;
    logic [1:0] m_conf  = '0;
    logic [3:0] m_nl;
    logic [3:0] m_np;
    logic [3:0] m_h;
    bit         m_one;
    bit         m_zero;
    bit         armed[4];
    int         since[4];

    task automatic model_clear();
        m_level = '0;
        m_press = '0;
        m_conf  = '0;
        hist.delete();
        for (int j = 0; j < D + 2; j++) hist.push_back(4'b0000);
        for (int i = 0; i < 4; i++) begin
            armed[i] = 1'b0;
            since[i] = 0;
        end
    endtask

    task automatic model_step();
        hist.push_back(btn_raw);
        if (hist.size() > D + 2) void'(hist.pop_front());
        for (int i = 0; i < 4; i++) begin
            m_one  = 1'b1;
            m_zero = 1'b1;
            for (int j = 0; j < D; j++) begin
                m_h = hist[j];
                if (m_h[i]) m_zero = 1'b0;
                else        m_one  = 1'b0;
            end
            m_nl[i] = m_one ? 1'b1 : (m_zero ? 1'b0 : m_level[i]);
        end
        for (int i = 0; i < 4; i++) begin
            m_np[i] = m_nl[i] & ~m_level[i] & ~m_nl[i ^ 1];
`ifdef BTN_AUTOREPEAT_EN
            if (m_np[i]) begin
                armed[i] = 1'b1;
                since[i] = 0;
            end else if (armed[i]) begin
                if (!m_nl[i] || m_nl[i ^ 1]) begin
                    armed[i] = 1'b0;
                end else begin
                    since[i] = since[i] + 1;
                    if (since[i] >= RD && ((since[i] - RD) % RR) == 0) m_np[i] = 1'b1;
                end
            end
`endif
        end
        m_conf  = {m_nl[3] & m_nl[2], m_nl[1] & m_nl[0]};
        m_level = m_nl;
        m_press = m_np;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_clear();
            else        model_step();
        end
    end

    // Expected outputs for this cycle are queued after the edge and any reset change settle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            exp_q.push_back({m_conf, m_press, m_level});
        end
    end

    // ---------------- monitor ----------------
    logic [9:0] exp_v;
    logic [9:0] got_v;

    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL queue_empty t=%0t got no expected entry, required one per cycle", $time);
            end else begin
                exp_v = exp_q.pop_front();
                got_v = {conflict, btn_press, btn_level};
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs t=%0t got conflict=%b press=%b level=%b required conflict=%b press=%b level=%b",
                             $time, got_v[9:8], got_v[7:4], got_v[3:0], exp_v[9:8], exp_v[7:4], exp_v[3:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        btn_raw = v;
        cycles(n);
    endtask

    task automatic pulse_reset(input int n);
        rst_n = 1'b0;
        cycles(n);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        btn_raw = '0;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // clean press and release
        hold(4'b0001, 12);
        hold(4'b0000, 10);

        // bounce on bit 1, then settle high
        hold(4'b0010, 2);
        hold(4'b0000, 2);
        hold(4'b0010, 2);
        hold(4'b0000, 2);
        hold(4'b0010, 12);
        hold(4'b0000, 10);

        // simultaneous presses per player, then P2 conflict while P1 presses cleanly
        hold(4'b0011, 10);
        hold(4'b0000, 10);
        hold(4'b1100, 10);
        hold(4'b1101, 12);
        hold(4'b0000, 10);

        // reset mid-debounce with bit 2 still held
        hold(4'b0100, 4);
        pulse_reset(4);
        cycles(12);
        hold(4'b0000, 10);

        // long hold for auto-repeat, then partner pressed while held
        hold(4'b1000, 45);
        hold(4'b0000, 10);
        hold(4'b0001, 20);
        hold(4'b0011, 10);
        hold(4'b0001, 20);
        hold(4'b0000, 10);

        // random activity with occasional resets
        repeat (300) begin
            if ($urandom_range(0, 19) == 0) pulse_reset($urandom_range(1, 3));
            btn_raw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) cycles($urandom_range(15, 40));
            else                           cycles($urandom_range(1, 12));
        end

        hold(4'b0000, 12);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
